// File: rtl/rom_ctrl_pkg.sv
// Shared types and constants for the ROM fetch sequencer and its queue.
package rom_ctrl_pkg;

  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 8;
  localparam int ROM_DEPTH = 16;
  localparam logic [DATA_W-1:0] HALT_OP = 8'hFF;

  // Highest populated cell; anything above it is outside the ROM.
  localparam logic [ADDR_W-1:0] ROM_LAST = ADDR_W'(ROM_DEPTH - 1);

  typedef enum logic {
    G_FETCH = 1'b0,
    G_LOAD  = 1'b1
  } gnt_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
  } q_entry_t;

  function automatic logic in_rom(input logic [ADDR_W-1:0] a);
    return a <= ROM_LAST;
  endfunction

  function automatic logic [ADDR_W-1:0] pc_wrap_inc(input logic [ADDR_W-1:0] a);
    return (a >= ROM_LAST) ? '0 : a + 1'b1;
  endfunction

endpackage

// File: rtl/rom_fetch_ctrl_if.sv
// Bundle of ROM port, decoder handshake and load-request signals.
interface rom_fetch_ctrl_if;
  import rom_ctrl_pkg::*;

  logic              run;
  logic              rom_oe;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              ins_valid;
  logic [DATA_W-1:0] ins_data;
  logic [ADDR_W-1:0] ins_addr;
  logic              ins_ready;
  logic              jmp_valid;
  logic [ADDR_W-1:0] jmp_addr;
  logic              ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_gnt;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic [ADDR_W-1:0] pc;
  logic              addr_err;
  logic              halted;

  modport master (
    input  run, rom_data, ins_ready, jmp_valid, jmp_addr, ld_req, ld_addr,
    output rom_oe, rom_addr, ins_valid, ins_data, ins_addr,
           ld_gnt, ld_valid, ld_data, pc, addr_err, halted
  );

  modport slave (
    output run, rom_data, ins_ready, jmp_valid, jmp_addr, ld_req, ld_addr,
    input  rom_oe, rom_addr, ins_valid, ins_data, ins_addr,
           ld_gnt, ld_valid, ld_data, pc, addr_err, halted
  );

endinterface

// File: rtl/rom_fetch_buf.sv
// Two-entry instruction queue; flush wins over push/pop in the same cycle.
module rom_fetch_buf
  import rom_ctrl_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push_i,
  input  logic     pop_i,
  input  logic     flush_i,
  input  q_entry_t din_i,
  output q_entry_t head_o,
  output logic [1:0] count_o
);

  q_entry_t   e0_q, e1_q;
  logic [1:0] count_q;

  // Entry 0 is always the head; entry 1 shifts down on pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q    <= '0;
      e1_q    <= '0;
      count_q <= 2'd0;
    end else if (flush_i) begin
      count_q <= 2'd0;
    end else if (push_i && pop_i) begin
      if (count_q == 2'd1) begin
        e0_q <= din_i;
      end else begin
        e0_q <= e1_q;
        e1_q <= din_i;
      end
    end else if (push_i) begin
      if (count_q == 2'd0) e0_q <= din_i;
      else                 e1_q <= din_i;
      count_q <= count_q + 2'd1;
    end else if (pop_i) begin
      e0_q    <= e1_q;
      count_q <= count_q - 2'd1;
    end
  end

  assign head_o  = e0_q;
  assign count_o = count_q;

endmodule

// File: rtl/rom_fetch_ctrl.sv
// Fetch sequencer and single-port ROM arbiter (fetch vs constant load).
// Optional macro ROM_FETCH_HALT_EN: stop fetching after a HALT_OP byte.
//
// grant state | meaning
// G_FETCH     | last granted access was a fetch (load wins next contention)
// G_LOAD      | last granted access was a load (fetch wins next contention)
module rom_fetch_ctrl
  import rom_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  rom_fetch_ctrl_if.master bus
);

  gnt_e              last_gnt_q;
  logic [ADDR_W-1:0] pc_q;
  logic              ld_valid_q;
  logic [DATA_W-1:0] ld_data_q;
  logic              addr_err_q;
  logic              halted_q;

  logic       fetch_el, load_el, do_fetch, do_load, pop;
  logic [1:0] count;
  q_entry_t   head, push_ent;

  // Per-cycle arbitration; nothing is granted while reset is asserted.
  always_comb begin
    fetch_el = bus.run & ~bus.jmp_valid & ~halted_q & (count < 2'd2);
    load_el  = bus.ld_req;
    do_fetch = 1'b0;
    do_load  = 1'b0;
    if (rst_n) begin
      if (fetch_el && load_el) begin
        do_load  = (last_gnt_q == G_FETCH);
        do_fetch = (last_gnt_q == G_LOAD);
      end else begin
        do_fetch = fetch_el;
        do_load  = load_el;
      end
    end
  end

  // ROM address mux; address parked at 0 when the port is idle.
  always_comb begin
    bus.rom_addr = '0;
    if (do_fetch)     bus.rom_addr = pc_q;
    else if (do_load) bus.rom_addr = bus.ld_addr;
  end

  assign bus.rom_oe = do_fetch | do_load;
  assign bus.ld_gnt = do_load;
  assign pop        = bus.ins_valid & bus.ins_ready;
  assign push_ent   = '{data: bus.rom_data, addr: pc_q};

  rom_fetch_buf u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (do_fetch),
    .pop_i   (pop),
    .flush_i (bus.jmp_valid),
    .din_i   (push_ent),
    .head_o  (head),
    .count_o (count)
  );

  // Grant history, PC, load result and sticky status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q <= G_FETCH;
      pc_q       <= '0;
      ld_valid_q <= 1'b0;
      ld_data_q  <= '0;
      addr_err_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      ld_valid_q <= do_load;
      if (do_load) begin
        last_gnt_q <= G_LOAD;
        if (in_rom(bus.ld_addr)) begin
          ld_data_q <= bus.rom_data;
        end else begin
          ld_data_q  <= '0;
          addr_err_q <= 1'b1;
        end
      end else if (do_fetch) begin
        last_gnt_q <= G_FETCH;
      end

      if (bus.jmp_valid) begin
        halted_q <= 1'b0;
        if (in_rom(bus.jmp_addr)) begin
          pc_q <= bus.jmp_addr;
        end else begin
          pc_q       <= '0;
          addr_err_q <= 1'b1;
        end
      end else if (do_fetch) begin
        pc_q <= pc_wrap_inc(pc_q);
`ifdef ROM_FETCH_HALT_EN
        if (bus.rom_data == HALT_OP) halted_q <= 1'b1;
`else
        halted_q <= 1'b0;
`endif
      end
    end
  end

  assign bus.ins_valid = (count != 2'd0);
  assign bus.ins_data  = head.data;
  assign bus.ins_addr  = head.addr;
  assign bus.ld_valid  = ld_valid_q;
  assign bus.ld_data   = ld_data_q;
  assign bus.pc        = pc_q;
  assign bus.addr_err  = addr_err_q;
  assign bus.halted    = halted_q;

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Directed bench for rom_fetch_ctrl; ROM cell k = 8'h10+k, cell 5 = 8'hFF.
`timescale 1ns/1ps
module tb_rom_fetch_ctrl;
  import rom_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [DATA_W-1:0] rom_mem [ROM_DEPTH];

  rom_fetch_ctrl_if bus ();

  rom_fetch_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    bus.rom_data = 8'h00;
    if (bus.rom_addr <= ROM_LAST) bus.rom_data = rom_mem[bus.rom_addr[3:0]];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_inputs();
    bus.run       = 1'b0;
    bus.ins_ready = 1'b0;
    bus.jmp_valid = 1'b0;
    bus.jmp_addr  = '0;
    bus.ld_req    = 1'b0;
    bus.ld_addr   = '0;
  endtask

  // Hold reset over two edges with requests asserted, then release just after an edge.
  task automatic do_reset(input bit chk);
    rst_n = 1'b0;
    clear_inputs();
    bus.run    = 1'b1;
    bus.ld_req = 1'b1;
    settle();
    if (chk) begin
      check_val("rst_rom_oe",    32'(bus.rom_oe),    32'd0);
      check_val("rst_ld_gnt",    32'(bus.ld_gnt),    32'd0);
      check_val("rst_pc",        32'(bus.pc),        32'd0);
      check_val("rst_ins_valid", 32'(bus.ins_valid), 32'd0);
      check_val("rst_ins_data",  32'(bus.ins_data),  32'd0);
      check_val("rst_ins_addr",  32'(bus.ins_addr),  32'd0);
      check_val("rst_ld_valid",  32'(bus.ld_valid),  32'd0);
      check_val("rst_ld_data",   32'(bus.ld_data),   32'd0);
      check_val("rst_addr_err",  32'(bus.addr_err),  32'd0);
      check_val("rst_halted",    32'(bus.halted),    32'd0);
    end
    @(posedge clk);
    next_cyc();
    clear_inputs();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] exp_b;
    for (int k = 0; k < ROM_DEPTH; k++) rom_mem[k] = 8'(8'h10 + k);
    rom_mem[5] = 8'hFF;

    // Streaming fetch with ready held high
    do_reset(1'b1);
    bus.run = 1'b1; bus.ins_ready = 1'b1;
    settle();
    check_val("c0_rom_oe",    32'(bus.rom_oe),    32'd1);
    check_val("c0_rom_addr",  32'(bus.rom_addr),  32'd0);
    check_val("c0_ins_valid", 32'(bus.ins_valid), 32'd0);
    next_cyc();
`ifndef ROM_FETCH_HALT_EN
    for (int i = 0; i < 18; i++) begin
      settle();
      exp_b = ((i % 16) == 5) ? 8'hFF : 8'(8'h10 + (i % 16));
      check_val("stream_data", 32'(bus.ins_data), 32'(exp_b));
      check_val("stream_addr", 32'(bus.ins_addr), 32'(i % 16));
      if (i == 15) check_val("pc_wrap", 32'(bus.pc), 32'd0);
      next_cyc();
    end
`else
    for (int i = 0; i < 6; i++) begin
      settle();
      exp_b = (i == 5) ? 8'hFF : 8'(8'h10 + i);
      check_val("halt_data", 32'(bus.ins_data), 32'(exp_b));
      if (i < 5) check_val("halt_oe_run", 32'(bus.rom_oe), 32'd1);
      next_cyc();
    end
    // Cycles 6/7: halted, no fetch despite room in the queue
    settle();
    check_val("halted_set", 32'(bus.halted), 32'd1);
    check_val("halt_oe_off", 32'(bus.rom_oe), 32'd0);
    next_cyc();
    bus.jmp_valid = 1'b1; bus.jmp_addr = 5'd0;
    settle();
    check_val("halt_oe_off2", 32'(bus.rom_oe), 32'd0);
    next_cyc();
    bus.jmp_valid = 1'b0;
    settle();
    check_val("halt_clr", 32'(bus.halted), 32'd0);
    check_val("halt_resume_oe", 32'(bus.rom_oe), 32'd1);
    check_val("halt_resume_addr", 32'(bus.rom_addr), 32'd0);
    next_cyc();
`endif

    // Back-pressure: two fetches fill the queue, then drain and resume
    do_reset(1'b0);
    bus.run = 1'b1;
    next_cyc();
    next_cyc();
    settle();
    check_val("full_oe", 32'(bus.rom_oe), 32'd0);
    check_val("full_head", 32'(bus.ins_data), 32'h10);
    check_val("full_pc", 32'(bus.pc), 32'd2);
    next_cyc();
    settle();
    check_val("full_oe2", 32'(bus.rom_oe), 32'd0);
    next_cyc();
    bus.ins_ready = 1'b1;
    settle();
    check_val("drain0", 32'(bus.ins_data), 32'h10);
    check_val("drain0_oe", 32'(bus.rom_oe), 32'd0);
    next_cyc();
    settle();
    check_val("drain1", 32'(bus.ins_data), 32'h11);
    check_val("resume_oe", 32'(bus.rom_oe), 32'd1);
    check_val("resume_addr", 32'(bus.rom_addr), 32'd2);
    next_cyc();
    settle();
    check_val("drain2", 32'(bus.ins_data), 32'h12);
    next_cyc();

    // Contention: load wins first, then alternate
    do_reset(1'b0);
    bus.run = 1'b1; bus.ins_ready = 1'b1; bus.ld_req = 1'b1; bus.ld_addr = 5'd3;
    settle();
    check_val("arb0_gnt", 32'(bus.ld_gnt), 32'd1);
    check_val("arb0_addr", 32'(bus.rom_addr), 32'd3);
    next_cyc();
    settle();
    check_val("arb1_ld_valid", 32'(bus.ld_valid), 32'd1);
    check_val("arb1_ld_data", 32'(bus.ld_data), 32'h13);
    check_val("arb1_gnt", 32'(bus.ld_gnt), 32'd0);
    check_val("arb1_addr", 32'(bus.rom_addr), 32'd0);
    next_cyc();
    settle();
    check_val("arb2_gnt", 32'(bus.ld_gnt), 32'd1);
    check_val("arb2_ld_valid", 32'(bus.ld_valid), 32'd0);
    check_val("arb2_head", 32'(bus.ins_data), 32'h10);
    next_cyc();
    settle();
    check_val("arb3_gnt", 32'(bus.ld_gnt), 32'd0);
    check_val("arb3_addr", 32'(bus.rom_addr), 32'd1);
    next_cyc();
    bus.ld_req = 1'b0;

    // Jump with a full queue and a pop in the same cycle
    do_reset(1'b0);
    bus.run = 1'b1;
    next_cyc();
    next_cyc();
    bus.jmp_valid = 1'b1; bus.jmp_addr = 5'd9; bus.ins_ready = 1'b1;
    settle();
    check_val("jmp_oe", 32'(bus.rom_oe), 32'd0);
    check_val("jmp_head", 32'(bus.ins_data), 32'h10);
    next_cyc();
    bus.jmp_valid = 1'b0;
    settle();
    check_val("jmp1_valid", 32'(bus.ins_valid), 32'd0);
    check_val("jmp1_pc", 32'(bus.pc), 32'd9);
    check_val("jmp1_addr", 32'(bus.rom_addr), 32'd9);
    next_cyc();
    settle();
    check_val("jmp2_valid", 32'(bus.ins_valid), 32'd1);
    check_val("jmp2_data", 32'(bus.ins_data), 32'h19);
    check_val("jmp2_addr", 32'(bus.ins_addr), 32'd9);
    next_cyc();

    // Out-of-range jump and load
    bus.jmp_valid = 1'b1; bus.jmp_addr = 5'd20;
    settle();
    check_val("oor_err_before", 32'(bus.addr_err), 32'd0);
    next_cyc();
    bus.jmp_valid = 1'b0; bus.run = 1'b0;
    settle();
    check_val("oor_pc", 32'(bus.pc), 32'd0);
    check_val("oor_err", 32'(bus.addr_err), 32'd1);
    check_val("run0_oe", 32'(bus.rom_oe), 32'd0);
    next_cyc();
    bus.ld_req = 1'b1; bus.ld_addr = 5'd3;
    next_cyc();
    bus.ld_addr = 5'd17;
    settle();
    check_val("ld17_gnt", 32'(bus.ld_gnt), 32'd1);
    check_val("ld17_rom_addr", 32'(bus.rom_addr), 32'd17);
    check_val("ld3_data", 32'(bus.ld_data), 32'h13);
    next_cyc();
    bus.ld_req = 1'b0;
    settle();
    check_val("ld17_valid", 32'(bus.ld_valid), 32'd1);
    check_val("ld17_data", 32'(bus.ld_data), 32'd0);
    check_val("err_sticky", 32'(bus.addr_err), 32'd1);
    next_cyc();

    // Reset during a granted load drops it; load out of range sets addr_err
    bus.ld_req = 1'b1; bus.ld_addr = 5'd4;
    settle();
    check_val("mid_gnt", 32'(bus.ld_gnt), 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_gnt", 32'(bus.ld_gnt), 32'd0);
    check_val("mid_rst_err", 32'(bus.addr_err), 32'd0);
    next_cyc();
    clear_inputs();
    rst_n = 1'b1;
    settle();
    check_val("mid_no_valid", 32'(bus.ld_valid), 32'd0);
    bus.ld_req = 1'b1; bus.ld_addr = 5'd17;
    next_cyc();
    bus.ld_req = 1'b0;
    settle();
    check_val("ld_err", 32'(bus.addr_err), 32'd1);
    next_cyc();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rom_fetch_ctrl.md
# rom_fetch_ctrl

Fetch sequencer and port arbiter for the 16-cell program ROM. Holds the program counter, drives the ROM's output-enable and address, and buffers fetched instruction bytes in a 2-entry queue for the decoder (valid/ready handshake). Shares the single ROM port between instruction fetch and constant-load requests, alternating when both compete, and handles jumps by flushing the queue.

## Interface
- ADDR_W, 5, ROM address width
- DATA_W, 8, ROM cell width
- ROM_DEPTH, 16, populated cells; PC wraps ROM_DEPTH-1 -> 0
- HALT_OP, 8'hFF, halt opcode (used only with ROM_FETCH_HALT_EN)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- run  in  1  fetch enable
- rom_oe  out  1  ROM output enable, high only in granted cycles
- rom_addr  out  ADDR_W  ROM address; 0 when rom_oe=0
- rom_data  in  DATA_W  ROM read data, combinational same cycle
- ins_valid  out  1  queue head valid
- ins_data  out  DATA_W  queue head byte
- ins_addr  out  ADDR_W  address the head byte was fetched from
- ins_ready  in  1  decoder accepts head
- jmp_valid  in  1  one-cycle jump strobe
- jmp_addr  in  ADDR_W  jump target
- ld_req  in  1  constant-load request, held until ld_gnt
- ld_addr  in  ADDR_W  load address, stable while ld_req
- ld_gnt  out  1  combinational grant for load this cycle
- ld_valid  out  1  one-cycle pulse, load data available
- ld_data  out  DATA_W  registered load result
- pc  out  ADDR_W  next fetch address
- addr_err  out  1  sticky: jump or load address >= ROM_DEPTH
- halted  out  1  fetch stopped on HALT_OP

## Operation
- One ROM access per cycle. Grant state register last_gnt in {G_FETCH, G_LOAD}; per-cycle decision IDLE / FETCH / LOAD.
- Fetch eligible: run=1, jmp_valid=0, halted=0, queue count < 2 (count sampled before this cycle's pop).
- Load eligible: ld_req=1.
- Both eligible: grant opposite of last_gnt. One eligible: grant it. last_gnt updates only on a grant.
- FETCH: rom_addr=pc, push {rom_data, pc}, pc <= wrap(pc+1).
- LOAD: rom_addr=ld_addr, ld_gnt=1, ld_data <= rom_data, ld_valid=1 next cycle. ld_addr >= ROM_DEPTH: ld_data <= 0, addr_err <= 1.
- Pop when ins_valid && ins_ready; push and pop in the same cycle are both performed.
- Jump: handshake of the current cycle completes, then queue flushed (count <= 0), pc <= jmp_addr, halted <= 0. jmp_addr >= ROM_DEPTH: pc <= 0, addr_err <= 1. Jump applies with run=0 too. Load grant unaffected.
- run deassertion stops new fetches; queue contents stay and drain normally.
- addr_err clears only on reset.

## Timing
- Reset values: pc=0, count=0, last_gnt=G_FETCH (load wins first contention), ins_valid=0, ins_data=0, ins_addr=0, ld_valid=0, ld_data=0, addr_err=0, halted=0. Combinational outputs rom_oe/ld_gnt are 0 while rst_n=0.
- Fetch-to-ins_valid latency: 1 cycle (fetch in cycle n, head valid in n+1 if queue was empty).
- Jump in cycle n: ins_valid=0 in n+1; first fetch at jmp_addr in n+1, valid in n+2.
- Load: ld_gnt in cycle n, ld_valid/ld_data in n+1 only.
- Reset asserted mid-operation: all state returns to reset values immediately; pending load is dropped (no ld_valid).

## Configuration
- ROM_FETCH_HALT_EN defined: a fetch returning HALT_OP sets halted=1 after pushing it; no further fetches until a jump or reset.
- Undefined: no opcode inspection; halted tied to 0; fetch continues with wrap-around.

## Structure
- Package rom_ctrl_pkg: grant enum (G_FETCH, G_LOAD), ROM_DEPTH, HALT_OP default, queue-entry type {data, addr}.
- Sub-module rom_fetch_buf: 2-entry FIFO with push/pop/flush and count; the arbiter and PC logic stay in rom_fetch_ctrl.

## Test plan
ROM loaded with cell k = 8'h10+k, cell 5 = 8'hFF.
- Reset, run=1, ins_ready=1 -> ins_data 8'h10,8'h11,... from cycle 1; after cell 15 pc wraps to 0, ins_data 8'h10 again (macro off).
- run=1, ins_ready=0 -> exactly 2 fetches, count=2, rom_oe=0 thereafter; ready=1 drains 8'h10, 8'h11 then resumes with 8'h12.
- ld_req held, addr 3, with run=1 and queue not full -> grants alternate LOAD, FETCH, LOAD; first ld_valid carries 8'h13.
- Queue holds two entries, jmp_valid addr 9 with ins_ready=1 -> head popped, queue flushed, next ins_data 8'h19 with ins_addr 9 two cycles later.
- jmp_addr 20 -> pc=0, addr_err=1 sticky; ld_addr 17 -> ld_data 0.
- ROM_FETCH_HALT_EN defined, run from 0 -> 8'h10..8'h14, 8'hFF delivered, halted=1, no further rom_oe for fetch; jump to 0 clears halted.
